// File: rtl/instr_decode.sv
// MIPS-lite decode stage: IF/ID register, register file, ID/EX register,
// early branch resolution, hazard stalls and HALT/illegal tracking.
module instr_decode #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              if_instruction,
  input  logic [ADDRESS_WIDTH-1:0] if_pc,
  output logic [ADDRESS_WIDTH-1:0] branch_addr,
  output logic                     is_taken,
  output logic                     fetch_stall,
  input  logic                     wb_wen,
  input  logic [4:0]               wb_addr,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     exmem_wen,
  input  logic [4:0]               exmem_dest,
  output logic                     idex_valid,
  output logic [5:0]               idex_opcode,
  output logic [DATA_WIDTH-1:0]    idex_rs_val,
  output logic [DATA_WIDTH-1:0]    idex_rt_val,
  output logic [DATA_WIDTH-1:0]    idex_imm,
  output logic [4:0]               idex_dest,
  output logic                     idex_wen,
  output logic                     idex_is_load,
  output logic                     idex_is_store,
  output logic                     idex_halt,
  output logic [ADDRESS_WIDTH-1:0] idex_pc,
  output logic                     halted,
  output logic                     illegal_seen
);

  localparam logic [5:0] OP_XORI = 6'h0B;
  localparam logic [5:0] OP_LDW  = 6'h0C;
  localparam logic [5:0] OP_STW  = 6'h0D;
  localparam logic [5:0] OP_BZ   = 6'h0E;
  localparam logic [5:0] OP_BEQ  = 6'h0F;
  localparam logic [5:0] OP_JR   = 6'h10;
  localparam logic [5:0] OP_HALT = 6'h11;

  typedef enum logic {
    S_RUN,
    S_HALTED
  } state_t;

  typedef struct packed {
    logic                     valid;
    logic [5:0]               opcode;
    logic [DATA_WIDTH-1:0]    rs_val;
    logic [DATA_WIDTH-1:0]    rt_val;
    logic [DATA_WIDTH-1:0]    imm;
    logic [4:0]               dest;
    logic                     wen;
    logic                     is_load;
    logic                     is_store;
    logic                     halt;
    logic [ADDRESS_WIDTH-1:0] pc;
  } idex_t;

  state_t                   state_q, state_d;
  logic                     illegal_q, illegal_d;
  logic                     id_valid_q, id_valid_d;
  logic [31:0]              id_instr_q, id_instr_d;
  logic [ADDRESS_WIDTH-1:0] id_pc_q, id_pc_d;
  idex_t                    idex_q, idex_d;
  logic [DATA_WIDTH-1:0]    rf_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]    rf_d [NUM_REGS];

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, dest;
  logic [15:0] imm16;
  logic is_arith, is_rtype, is_ldw, is_stw;
  logic is_bz, is_beq, is_jr, is_halt, is_ill;
  logic is_br, uses_rs, uses_rt, wen;
  logic [DATA_WIDTH-1:0] rs_val, rt_val, imm_ext;
  logic [ADDRESS_WIDTH-1:0] br_off;
  logic run, load_use, br_haz, stall, resolve, take;
  logic ex_rs, ex_rt, mem_rs, mem_rt;

  always_comb begin
    op       = id_instr_q[31:26];
    rs       = id_instr_q[25:21];
    rt       = id_instr_q[20:16];
    rd       = id_instr_q[15:11];
    imm16    = id_instr_q[15:0];
    is_arith = op <= OP_XORI;
    is_rtype = is_arith & ~op[0];
    is_ldw   = op == OP_LDW;
    is_stw   = op == OP_STW;
    is_bz    = op == OP_BZ;
    is_beq   = op == OP_BEQ;
    is_jr    = op == OP_JR;
    is_halt  = op == OP_HALT;
    is_ill   = op > OP_HALT;
    is_br    = is_bz | is_beq | is_jr;
    uses_rs  = is_arith | is_ldw | is_stw | is_br;
    uses_rt  = is_rtype | is_stw | is_beq;
    imm_ext  = {{(DATA_WIDTH-16){imm16[15]}}, imm16};
    br_off   = {{(ADDRESS_WIDTH-18){imm16[15]}}, imm16, 2'b00};
    dest     = 5'd0;
    wen      = 1'b0;
    unique case (1'b1)
      is_rtype: begin
        dest = rd;
        wen  = 1'b1;
      end
      (is_arith & op[0]) | is_ldw: begin
        dest = rt;
        wen  = 1'b1;
      end
      default: ;
    endcase
  end

  // Same-cycle writeback is forwarded so decode never sees a stale value.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0)
      rs_val = (wb_wen && wb_addr == rs) ? wb_data : rf_q[rs];
    if (rt != 5'd0)
      rt_val = (wb_wen && wb_addr == rt) ? wb_data : rf_q[rt];
  end

  always_comb begin
    run = state_q == S_RUN;
    ex_rs = idex_q.valid & idex_q.wen &
            idex_q.dest != 5'd0 & idex_q.dest == rs;
    ex_rt = idex_q.valid & idex_q.wen &
            idex_q.dest != 5'd0 & idex_q.dest == rt;
    mem_rs = exmem_wen & exmem_dest != 5'd0 &
             exmem_dest == rs;
    mem_rt = exmem_wen & exmem_dest != 5'd0 &
             exmem_dest == rt;
    load_use = idex_q.is_load &
               ((uses_rs & ex_rs) | (uses_rt & ex_rt));
    br_haz = is_br & ((uses_rs & (ex_rs | mem_rs)) |
                      (uses_rt & (ex_rt | mem_rt)));
    stall   = run & id_valid_q & (load_use | br_haz);
    resolve = run & id_valid_q & ~stall;
    take    = 1'b0;
    unique case (1'b1)
      is_bz:   take = rs_val == '0;
      is_beq:  take = rs_val == rt_val;
      is_jr:   take = 1'b1;
      default: take = 1'b0;
    endcase
    is_taken    = resolve & take;
    fetch_stall = ~run | stall;
    branch_addr = '0;
    if (is_taken)
      branch_addr = is_jr ? ADDRESS_WIDTH'(rs_val)
                          : id_pc_q + br_off;
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q | (resolve & is_ill);
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    idex_d     = '0;
    rf_d       = rf_q;
    if (wb_wen && wb_addr != 5'd0)
      rf_d[wb_addr] = wb_data;
    if (run && !stall) begin
      id_valid_d = ~is_taken;
      id_instr_d = if_instruction;
      id_pc_d    = if_pc;
    end
    if (resolve && !is_ill) begin
      idex_d.valid    = 1'b1;
      idex_d.opcode   = op;
      idex_d.rs_val   = rs_val;
      idex_d.rt_val   = rt_val;
      idex_d.imm      = imm_ext;
      idex_d.dest     = dest;
      idex_d.wen      = wen;
      idex_d.is_load  = is_ldw;
      idex_d.is_store = is_stw;
      idex_d.halt     = is_halt;
      idex_d.pc       = id_pc_q;
    end
    if (resolve && is_halt)
      state_d = S_HALTED;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      illegal_q  <= 1'b0;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      idex_q     <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        rf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      illegal_q  <= illegal_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      idex_q     <= idex_d;
      rf_q       <= rf_d;
    end
  end

  assign idex_valid    = idex_q.valid;
  assign idex_opcode   = idex_q.opcode;
  assign idex_rs_val   = idex_q.rs_val;
  assign idex_rt_val   = idex_q.rt_val;
  assign idex_imm      = idex_q.imm;
  assign idex_dest     = idex_q.dest;
  assign idex_wen      = idex_q.wen;
  assign idex_is_load  = idex_q.is_load;
  assign idex_is_store = idex_q.is_store;
  assign idex_halt     = idex_q.halt;
  assign idex_pc       = idex_q.pc;
  assign halted        = state_q == S_HALTED;
  assign illegal_seen  = illegal_q;

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: scoreboard of ID/EX issues plus
// cycle-by-cycle checks of the fetch-facing outputs.
module tb_instr_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_instruction, if_pc;
  logic [31:0] branch_addr;
  logic        is_taken, fetch_stall;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        exmem_wen;
  logic [4:0]  exmem_dest;
  logic        idex_valid;
  logic [5:0]  idex_opcode;
  logic [31:0] idex_rs_val, idex_rt_val, idex_imm;
  logic [4:0]  idex_dest;
  logic        idex_wen, idex_is_load, idex_is_store, idex_halt;
  logic [31:0] idex_pc;
  logic        halted, illegal_seen;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        wen;
    logic        ld;
    logic        st;
    logic        halt;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  instr_decode dut (
    .clk(clk), .reset(reset),
    .if_instruction(if_instruction), .if_pc(if_pc),
    .branch_addr(branch_addr), .is_taken(is_taken),
    .fetch_stall(fetch_stall),
    .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
    .exmem_wen(exmem_wen), .exmem_dest(exmem_dest),
    .idex_valid(idex_valid), .idex_opcode(idex_opcode),
    .idex_rs_val(idex_rs_val), .idex_rt_val(idex_rt_val),
    .idex_imm(idex_imm), .idex_dest(idex_dest),
    .idex_wen(idex_wen), .idex_is_load(idex_is_load),
    .idex_is_store(idex_is_store), .idex_halt(idex_halt),
    .idex_pc(idex_pc), .halted(halted),
    .illegal_seen(illegal_seen)
  );

  always #5 clk = ~clk;

  function automatic exp_t act_now();
    return {idex_opcode, idex_rs_val, idex_rt_val, idex_imm,
            idex_dest, idex_wen, idex_is_load, idex_is_store,
            idex_halt, idex_pc};
  endfunction

  function automatic exp_t mk(logic [5:0] op, logic [31:0] a,
                              logic [31:0] b, logic [31:0] imm,
                              logic [4:0] d, logic w, logic ld,
                              logic st, logic h, logic [31:0] pc);
    return {op, a, b, imm, d, w, ld, st, h, pc};
  endfunction

  function automatic logic [31:0] ri(logic [5:0] op, logic [4:0] s,
                                     logic [4:0] t, logic [4:0] d);
    return {op, s, t, d, 11'd0};
  endfunction

  function automatic logic [31:0] ii(logic [5:0] op, logic [4:0] s,
                                     logic [4:0] t, logic [15:0] im);
    return {op, s, t, im};
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic [31:0] ins, logic [31:0] pc);
    if_instruction = ins;
    if_pc          = pc;
  endtask

  task automatic wb(logic w, logic [4:0] a, logic [31:0] d);
    wb_wen  = w;
    wb_addr = a;
    wb_data = d;
  endtask

  // Monitor: every valid ID/EX entry must match the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (idex_valid === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got %h expected none",
                   act_now());
        end else begin
          e = exp_q.pop_front();
          if (act_now() !== e) begin
            fails++;
            $display("FAIL sb_idex: got %h expected %h",
                     act_now(), e);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    drv(32'd0, 32'd0);
    wb(1'b0, 5'd0, 32'd0);
    exmem_wen  = 1'b0;
    exmem_dest = 5'd0;
    repeat (2) step();
    #1;
    tests++;
    if (act_now() !== '0 || idex_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_idex: got %h expected 0", act_now());
    end
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_seen}, 32'd0);
    chk("rst_stall", {31'd0, fetch_stall}, 32'd0);
    chk("rst_taken", {31'd0, is_taken}, 32'd0);

    // ADD R3,R1,R1 with R1=5 written just before
    step(); reset = 1'b0;
    wb(1'b1, 5'd1, 32'd5);
    drv(ri(6'h00, 5'd1, 5'd1, 5'd3), 32'h10);
    exp_q.push_back(mk(6'h00, 5, 5, 32'h1800, 3, 1, 0, 0, 0, 32'h10));
    step(); wb(1'b0, 5'd0, 32'd0);
    drv(ii(6'h0C, 5'd1, 5'd2, 16'd0), 32'h14);
    exp_q.push_back(mk(6'h0C, 5, 0, 0, 2, 1, 1, 0, 0, 32'h14));
    step();
    drv(ii(6'h01, 5'd2, 5'd4, 16'd1), 32'h18);
    exp_q.push_back(mk(6'h01, 0, 0, 1, 4, 1, 0, 0, 0, 32'h18));
    #1; chk("ldw_no_stall", {31'd0, fetch_stall}, 32'd0);
    step(); #1;
    chk("ldu_stall", {31'd0, fetch_stall}, 32'd1);
    chk("ldu_no_take", {31'd0, is_taken}, 32'd0);
    step();
    drv(ii(6'h0E, 5'd5, 5'd0, 16'd3), 32'h40);
    exp_q.push_back(mk(6'h0E, 0, 0, 3, 0, 0, 0, 0, 0, 32'h40));
    #1; chk("ldu_release", {31'd0, fetch_stall}, 32'd0);

    // BZ R5,+3 at 0x40 with R5=0, then again with R5=7
    step();
    drv(ri(6'h00, 5'd1, 5'd1, 5'd7), 32'h44);
    #1;
    chk("bz_taken", {31'd0, is_taken}, 32'd1);
    chk("bz_addr", branch_addr, 32'h4C);
    step();
    wb(1'b1, 5'd5, 32'd7);
    drv(ii(6'h0E, 5'd5, 5'd0, 16'd3), 32'h40);
    exp_q.push_back(mk(6'h0E, 7, 0, 3, 0, 0, 0, 0, 0, 32'h40));
    #1;
    chk("flush_taken", {31'd0, is_taken}, 32'd0);
    chk("flush_stall", {31'd0, fetch_stall}, 32'd0);
    step(); wb(1'b0, 5'd0, 32'd0);
    drv(32'd0, 32'h44);
    exp_q.push_back(mk(6'h00, 0, 0, 0, 0, 1, 0, 0, 0, 32'h44));
    #1;
    chk("bz_nt_taken", {31'd0, is_taken}, 32'd0);
    chk("bz_nt_addr", branch_addr, 32'd0);

    // ADDI R6,R0,8 then JR R6: EX stall, MEM stall, WB bypass
    step();
    drv(ii(6'h01, 5'd0, 5'd6, 16'd8), 32'h50);
    exp_q.push_back(mk(6'h01, 0, 0, 8, 6, 1, 0, 0, 0, 32'h50));
    #1; chk("bz_nt_flow", {31'd0, fetch_stall}, 32'd0);
    step();
    drv(ii(6'h10, 5'd6, 5'd0, 16'd0), 32'h54);
    step(); #1;
    chk("jr_stall_ex", {31'd0, fetch_stall}, 32'd1);
    chk("jr_ex_no_take", {31'd0, is_taken}, 32'd0);
    step();
    exmem_wen = 1'b1; exmem_dest = 5'd6;
    #1;
    chk("jr_stall_mem", {31'd0, fetch_stall}, 32'd1);
    chk("jr_mem_no_take", {31'd0, is_taken}, 32'd0);
    step();
    exmem_wen = 1'b0; exmem_dest = 5'd0;
    wb(1'b1, 5'd6, 32'd8);
    drv(ri(6'h00, 5'd1, 5'd1, 5'd7), 32'h58);
    exp_q.push_back(mk(6'h10, 8, 0, 0, 0, 0, 0, 0, 0, 32'h54));
    #1;
    chk("jr_go", {31'd0, fetch_stall}, 32'd0);
    chk("jr_taken", {31'd0, is_taken}, 32'd1);
    chk("jr_addr", branch_addr, 32'd8);

    // HALT: issued once, then held
    step(); wb(1'b0, 5'd0, 32'd0);
    drv({6'h11, 26'd0}, 32'h8);
    exp_q.push_back(mk(6'h11, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8));
    #1; chk("jr_flush", {31'd0, is_taken}, 32'd0);
    step();
    drv(32'd0, 32'hC);
    #1;
    chk("halt_id_stall", {31'd0, fetch_stall}, 32'd0);
    chk("halt_id_halted", {31'd0, halted}, 32'd0);
    for (int k = 0; k < 12; k++) begin
      step();
      drv(ii(6'h0E, 5'd0, 5'd0, 16'(k)), 32'h100);
      #1;
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_stall", {31'd0, fetch_stall}, 32'd1);
      chk("halt_no_take", {31'd0, is_taken}, 32'd0);
    end
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    drv(32'hFC00_0000, 32'h60);
    #1;
    tests++;
    if (act_now() !== '0 || idex_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst2_idex: got %h expected 0", act_now());
    end
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_stall", {31'd0, fetch_stall}, 32'd0);
    chk("rst2_taken", {31'd0, is_taken}, 32'd0);

    // Illegal opcode, then R0 write ignored (also under bypass)
    step();
    wb(1'b1, 5'd0, 32'd9);
    drv(ri(6'h00, 5'd0, 5'd0, 5'd8), 32'h64);
    exp_q.push_back(mk(6'h00, 0, 0, 32'h4000, 8, 1, 0, 0, 0, 32'h64));
    step();
    drv(32'd0, 32'h68);
    #1;
    chk("ill_valid", {31'd0, idex_valid}, 32'd0);
    chk("ill_seen", {31'd0, illegal_seen}, 32'd1);
    step(); wb(1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    #1;
    chk("ill_sticky", {31'd0, illegal_seen}, 32'd1);
    repeat (2) step();
    #1;
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
